// File: rtl/vector_requantize_unit.sv
// Requantizes one row of signed accumulators to signed DATA_WIDTH values,
// one element per clock: bias add, round-half-up shift, optional ReLU, saturate.
module vector_requantize_unit #(
  parameter int ACCUM_WIDTH = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int N_DIM       = 2,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       op_start,
  input  logic signed [N_DIM-1:0][ACCUM_WIDTH-1:0]   input_vector_O,
  input  logic signed [N_DIM-1:0][ACCUM_WIDTH-1:0]   bias_vector,
  input  logic        [SHIFT_WIDTH-1:0]              shift_amt,
  input  logic                                       relu_en,
  output logic signed [N_DIM-1:0][DATA_WIDTH-1:0]    output_vector_Q,
  output logic                                       op_busy,
  output logic                                       op_done
);

  // Two guard bits so the bias add and rounding offset can never wrap.
  localparam int SW = ACCUM_WIDTH + 2;
  localparam int IW = (N_DIM > 1) ? $clog2(N_DIM) : 1;

  localparam logic signed [SW-1:0] Q_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] Q_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                                   state_q;
  logic [IW-1:0]                            idx_q;
  logic [N_DIM-1:0][ACCUM_WIDTH-1:0]        o_q;
  logic [N_DIM-1:0][ACCUM_WIDTH-1:0]        b_q;
  logic [SHIFT_WIDTH-1:0]                   shift_q;
  logic                                     relu_q;
  logic [N_DIM-1:0][DATA_WIDTH-1:0]         q_q;
  logic                                     busy_q;
  logic                                     done_q;

  logic signed [SW-1:0]                     sum_w;
  logic signed [SW-1:0]                     rnd_w;
  logic signed [SW-1:0]                     res_w;
  logic        [DATA_WIDTH-1:0]             elem_d;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    sum_w  = $signed({{2{o_q[idx_q][ACCUM_WIDTH-1]}}, o_q[idx_q]})
           + $signed({{2{b_q[idx_q][ACCUM_WIDTH-1]}}, b_q[idx_q]});
    rnd_w  = (shift_q == '0) ? '0 : (SW'(1) << (shift_q - 1'b1));
    res_w  = (sum_w + rnd_w) >>> shift_q;
    if (relu_q && (res_w < 0)) begin
      res_w = '0;
    end
    if (res_w > Q_MAX) begin
      elem_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (res_w < Q_MIN) begin
      elem_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      elem_d = res_w[DATA_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the snapshot and output arrays are flops, not RAM, and are cleared on
  // reset so an aborted operation leaves no stale data visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      o_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_start) begin
            o_q     <= input_vector_O;
            b_q     <= bias_vector;
            shift_q <= shift_amt;
            relu_q  <= relu_en;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          q_q[idx_q] <= elem_d;
          if (idx_q == IW'(N_DIM - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign output_vector_Q = q_q;
  assign op_busy         = busy_q;
  assign op_done         = done_q;

endmodule

// File: tb/tb_vector_requantize_unit.sv
// Directed bench for vector_requantize_unit (N_DIM=2): vector table with full
// handshake timing checks, plus start-robustness, held-start and mid-op reset.
module tb_vector_requantize_unit;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int N  = 2;
  localparam int SW = 5;

  logic                          clk;
  logic                          rst;
  logic                          op_start;
  logic signed [N-1:0][AW-1:0]   input_vector_O;
  logic signed [N-1:0][AW-1:0]   bias_vector;
  logic        [SW-1:0]          shift_amt;
  logic                          relu_en;
  logic signed [N-1:0][DW-1:0]   output_vector_Q;
  logic                          op_busy;
  logic                          op_done;

  vector_requantize_unit #(
    .ACCUM_WIDTH(AW), .DATA_WIDTH(DW), .N_DIM(N), .SHIFT_WIDTH(SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .op_start        (op_start),
    .input_vector_O  (input_vector_O),
    .bias_vector     (bias_vector),
    .shift_amt       (shift_amt),
    .relu_en         (relu_en),
    .output_vector_Q (output_vector_Q),
    .op_busy         (op_busy),
    .op_done         (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         o0, o1, b0, b1;
    logic [4:0] shift;
    logic       relu;
    int         q0, q1;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  vec_t tbl [12];

  always @(posedge clk) if (op_done) done_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int q_el(input int i);
    return int'($signed(output_vector_Q[i]));
  endfunction

  task automatic drive(input vec_t v);
    input_vector_O = {v.o1, v.o0};
    bias_vector    = {v.b1, v.b0};
    shift_amt      = v.shift;
    relu_en        = v.relu;
  endtask

  // Starts one op and checks busy/done/Q cycle by cycle; prev_q1 is the value
  // element 1 must still hold after only element 0 has been rewritten.
  task automatic run_op(input string tag, input vec_t v, input int prev_q1);
    int d0;
    @(negedge clk);
    drive(v);
    op_start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);  // E0
    #1 op_start = 1'b0;
    check({tag, " busy@E0"}, int'(op_busy), 1);
    check({tag, " done@E0"}, int'(op_done), 0);
    @(posedge clk); #1;  // E0+1
    check({tag, " busy@E1"}, int'(op_busy), 1);
    check({tag, " q0@E1"}, q_el(0), v.q0);
    check({tag, " q1 held@E1"}, q_el(1), prev_q1);
    @(posedge clk); #1;  // E0+2
    check({tag, " busy@E2"}, int'(op_busy), 0);
    check({tag, " done@E2"}, int'(op_done), 1);
    check({tag, " q0"}, q_el(0), v.q0);
    check({tag, " q1"}, q_el(1), v.q1);
    @(posedge clk); #1;  // E0+3
    check({tag, " done@E3"}, int'(op_done), 0);
    check({tag, " done count"}, done_cnt - d0, 1);
  endtask

  initial begin
    int   prev_q1;
    int   d0;
    vec_t v;

    tbl[0]  = '{13, 16, 0, 0, 5'd0, 1'b0, 13, 16};
    tbl[1]  = '{5, -5, 0, 0, 5'd1, 1'b0, 3, -2};
    tbl[2]  = '{6, -6, 1, 0, 5'd2, 1'b0, 2, -1};
    tbl[3]  = '{1000, -1000, 0, 0, 5'd0, 1'b0, 127, -128};
    tbl[4]  = '{100, -20, 27, -10, 5'd0, 1'b0, 127, -30};
    tbl[5]  = '{32'h7fff_ffff, 32'h8000_0000, 1, -1, 5'd0, 1'b0, 127, -128};
    tbl[6]  = '{-7, 9, 0, 0, 5'd0, 1'b1, 0, 9};
    tbl[7]  = '{-7, 9, 0, 0, 5'd0, 1'b0, -7, 9};
    tbl[8]  = '{-3, 3, 0, 0, 5'd1, 1'b0, -1, 2};
    tbl[9]  = '{-1000, 300, 0, 0, 5'd0, 1'b1, 0, 127};
    tbl[10] = '{32'h7fff_ffff, 32'h8000_0000, 32'h7fff_ffff, 32'h8000_0000, 5'd31, 1'b0, 2, -2};
    tbl[11] = '{-1, 1, 0, 0, 5'd31, 1'b0, 0, 0};

    rst = 1'b1;
    op_start = 1'b0;
    drive(tbl[0]);
    #12;
    check("reset q0", q_el(0), 0);
    check("reset q1", q_el(1), 0);
    check("reset busy", int'(op_busy), 0);
    check("reset done", int'(op_done), 0);
    @(negedge clk) rst = 1'b0;

    prev_q1 = 0;
    for (int k = 0; k < 12; k++) begin
      run_op($sformatf("vec%0d", k), tbl[k], prev_q1);
      prev_q1 = tbl[k].q1;
    end

    // Inputs change and op_start pulses through RUN and DONE; snapshot wins.
    @(negedge clk);
    drive(tbl[0]);
    op_start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);  // E0
    #1;
    v = '{100, 100, 50, 50, 5'd3, 1'b1, 0, 0};
    drive(v);
    repeat (3) @(posedge clk);  // E0+1..E0+3, ignored in RUN/DONE
    #1 op_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("robust q0", q_el(0), 13);
    check("robust q1", q_el(1), 16);
    check("robust done count", done_cnt - d0, 1);
    check("robust busy idle", int'(op_busy), 0);

    // op_start held high: starts at E0 and E0+4 only within 8 edges.
    @(negedge clk);
    drive(tbl[1]);
    op_start = 1'b1;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1 op_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held start done count", done_cnt - d0, 2);
    check("held start q0", q_el(0), 3);
    check("held start q1", q_el(1), -2);

    // Reset one cycle after the start edge aborts the op with no done.
    @(negedge clk);
    drive('{50, 60, 0, 0, 5'd0, 1'b0, 50, 60});
    op_start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);  // E0
    #1 op_start = 1'b0;
    @(posedge clk);  // E0+1
    #1 rst = 1'b1;
    #1;
    check("abort q0", q_el(0), 0);
    check("abort q1", q_el(1), 0);
    check("abort busy", int'(op_busy), 0);
    check("abort done", int'(op_done), 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort no done", done_cnt - d0, 0);
    check("abort stays idle", int'(op_busy), 0);
    run_op("post-reset", tbl[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
